// File: rtl/sched_pkg.sv
// Shared types and constants for the dual-issue scheduler: default latencies,
// writeback pipe entry, and the active-low register-file enable levels.
package sched_pkg;
    localparam int ALU_LAT_DEF = 1;
    localparam int MEM_LAT_DEF = 2;

    typedef struct packed {
        logic       valid;
        logic [4:0] addr;
    } wb_entry;

    localparam logic EN_ON  = 1'b0;
    localparam logic EN_OFF = 1'b1;
endpackage

// File: rtl/wb_port_pipe.sv
// One register-file write port: a per-cycle reservation vector plus the
// writeback pipe whose head drives the port's enable and address.
module wb_port_pipe
    import sched_pkg::*;
#(
    parameter int DEPTH = MEM_LAT_DEF
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       wr_en,
    input  logic [1:0] lat,
    input  logic [4:0] addr,
    output logic       free_at_lat,
    output wb_entry    head
);
    logic [DEPTH-1:0] res_reg;
    logic [DEPTH-1:0] res_next;
    logic [DEPTH-1:0] lat_sel;
    logic [DEPTH-1:0] claim;
    wb_entry          stage_reg  [DEPTH];
    wb_entry          stage_next [DEPTH];

    // Stage j holds the write that reaches the head j cycles from now, so a
    // writer with latency L enters at stage L-1 on the issue edge.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            assign lat_sel[gi] = (lat == 2'(gi + 1));
            assign claim[gi]   = wr_en && lat_sel[gi];
            if (gi < DEPTH - 1) begin : g_mid
                assign stage_next[gi] = claim[gi] ? '{valid: 1'b1, addr: addr} : stage_reg[gi+1];
            end else begin : g_top
                assign stage_next[gi] = claim[gi] ? '{valid: 1'b1, addr: addr} : '0;
            end
        end
    endgenerate

    assign free_at_lat = ~|(res_reg & lat_sel);
    assign res_next    = (res_reg | claim) >> 1;
    assign head        = stage_reg[0];

    always_ff @(posedge clk) begin
        if (srst) begin
            res_reg <= '0;
            for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
        end else begin
            res_reg <= res_next;
            for (int i = 0; i < DEPTH; i++) stage_reg[i] <= stage_next[i];
        end
    end
endmodule

// File: rtl/issue_scheduler.sv
// Dual-issue in-order scheduler: countdown scoreboard for RAW/WAW hazards,
// per-port write reservations, and registered writeback enables/addresses.
module issue_scheduler
    import sched_pkg::*;
#(
    parameter int ALU_LAT = ALU_LAT_DEF,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic       reloj,
    input  logic       reset,
    input  logic       V1,
    input  logic       V2,
    input  logic [4:0] SA1,
    input  logic [4:0] SB1,
    input  logic [4:0] SA2,
    input  logic [4:0] SB2,
    input  logic       UA1,
    input  logic       UB1,
    input  logic       UA2,
    input  logic       UB2,
    input  logic [4:0] DST1,
    input  logic [4:0] DST2,
    input  logic       WR1,
    input  logic       WR2,
    input  logic       MEM1,
    input  logic       MEM2,
    output logic       ISSUE1,
    output logic       ISSUE2,
    output logic       STALL,
    output logic       REG_RD1,
    output logic       REG_RD2,
    output logic       REG_WR1,
    output logic       REG_WR2,
    output logic [4:0] DIR_WRA1,
    output logic [4:0] DIR_WRA2
);
    localparam logic [1:0] L_ALU = 2'(ALU_LAT);
    localparam logic [1:0] L_MEM = 2'(MEM_LAT);

    logic [1:0]  cnt_reg  [32];
    logic [1:0]  cnt_next [32];
    logic [31:0] busy;
    logic [1:0]  lat1, lat2;
    logic        free1, free2;
    logic        ok1, ok2, raw2, waw2;
    wb_entry     head1, head2;

    assign lat1 = MEM1 ? L_MEM : L_ALU;
    assign lat2 = MEM2 ? L_MEM : L_ALU;

    assign ok1 = V1 && !(UA1 && busy[SA1]) && !(UB1 && busy[SB1])
                 && (!WR1 || (free1 && !busy[DST1]));
    assign ok2 = V2 && !(UA2 && busy[SA2]) && !(UB2 && busy[SB2])
                 && (!WR2 || (free2 && !busy[DST2]));
    assign raw2 = WR1 && ((UA2 && SA2 == DST1) || (UB2 && SB2 == DST1));
    assign waw2 = WR1 && WR2 && (DST2 == DST1);

    assign ISSUE1  = !reset && ok1;
    assign ISSUE2  = ISSUE1 && ok2 && !raw2 && !waw2 && !(MEM1 && MEM2);
    assign STALL   = !reset && V1 && !ISSUE1;
    assign REG_RD1 = ISSUE1 ? EN_ON : EN_OFF;
    assign REG_RD2 = ISSUE2 ? EN_ON : EN_OFF;

    // A fresh load of the countdown overrides the per-cycle decrement; r0 stays idle.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_sb
            assign busy[gi] = (cnt_reg[gi] != 2'd0);
            if (gi == 0) begin : g_zero
                assign cnt_next[gi] = 2'd0;
            end else begin : g_reg
                assign cnt_next[gi] =
                    (ISSUE1 && WR1 && DST1 == 5'(gi)) ? lat1 :
                    (ISSUE2 && WR2 && DST2 == 5'(gi)) ? lat2 :
                    busy[gi] ? cnt_reg[gi] - 2'd1 : 2'd0;
            end
        end
    endgenerate

    always_ff @(posedge reloj) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) cnt_reg[r] <= 2'd0;
        end else begin
            for (int r = 0; r < 32; r++) cnt_reg[r] <= cnt_next[r];
        end
    end

    wb_port_pipe #(.DEPTH(MEM_LAT)) u_port1 (
        .clk        (reloj),
        .srst       (reset),
        .wr_en      (ISSUE1 && WR1),
        .lat        (lat1),
        .addr       (DST1),
        .free_at_lat(free1),
        .head       (head1)
    );

    wb_port_pipe #(.DEPTH(MEM_LAT)) u_port2 (
        .clk        (reloj),
        .srst       (reset),
        .wr_en      (ISSUE2 && WR2),
        .lat        (lat2),
        .addr       (DST2),
        .free_at_lat(free2),
        .head       (head2)
    );

    assign REG_WR1  = head1.valid ? EN_ON : EN_OFF;
    assign REG_WR2  = head2.valid ? EN_ON : EN_OFF;
    assign DIR_WRA1 = head1.addr;
    assign DIR_WRA2 = head2.addr;
endmodule

// File: tb/tb_issue_scheduler.sv
// Randomized plus directed bench for issue_scheduler with a cycle-indexed
// reference model and a scoreboard queue drained by an independent monitor.
module tb_issue_scheduler;
    localparam int ALU_L = 1;
    localparam int MEM_L = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       V1, V2, UA1, UB1, UA2, UB2, WR1, WR2, MEM1, MEM2;
    logic [4:0] SA1, SB1, SA2, SB2, DST1, DST2;
    logic       ISSUE1, ISSUE2, STALL, REG_RD1, REG_RD2, REG_WR1, REG_WR2;
    logic [4:0] DIR_WRA1, DIR_WRA2;

    issue_scheduler #(.ALU_LAT(ALU_L), .MEM_LAT(MEM_L)) dut (
        .reloj(clk), .reset(reset),
        .V1(V1), .V2(V2),
        .SA1(SA1), .SB1(SB1), .SA2(SA2), .SB2(SB2),
        .UA1(UA1), .UB1(UB1), .UA2(UA2), .UB2(UB2),
        .DST1(DST1), .DST2(DST2), .WR1(WR1), .WR2(WR2),
        .MEM1(MEM1), .MEM2(MEM2),
        .ISSUE1(ISSUE1), .ISSUE2(ISSUE2), .STALL(STALL),
        .REG_RD1(REG_RD1), .REG_RD2(REG_RD2),
        .REG_WR1(REG_WR1), .REG_WR2(REG_WR2),
        .DIR_WRA1(DIR_WRA1), .DIR_WRA2(DIR_WRA2)
    );

    always #5 clk = ~clk;

    typedef struct { logic v, ua, ub, wr, mem; logic [4:0] sa, sb, dst; } cand_t;
    typedef struct { logic i1, i2, st, rd1, rd2, wr1, wr2; logic [4:0] a1, a2; int c; } exp_t;
    typedef struct { int due; logic [4:0] addr; } pend_t;

    exp_t  expq[$];
    pend_t pq1[$];
    pend_t pq2[$];
    int    ready_at[32];   // first cycle a register may be read or rewritten
    int    cyc;
    int    n_pass;
    int    n_total;
    exp_t  mon_e;

    function automatic cand_t mk(bit v, int sa, bit ua, int sb, bit ub, int dst, bit wr, bit mem);
        cand_t c;
        c.v = v; c.sa = 5'(sa); c.ua = ua; c.sb = 5'(sb); c.ub = ub;
        c.dst = 5'(dst); c.wr = wr; c.mem = mem;
        return c;
    endfunction

    function automatic cand_t rnd();
        cand_t c;
        c.v   = ($urandom_range(3) != 0);
        c.sa  = 5'($urandom_range(7));
        c.sb  = 5'($urandom_range(7));
        c.dst = 5'($urandom_range(7));
        c.ua  = 1'($urandom_range(1));
        c.ub  = 1'($urandom_range(1));
        c.wr  = 1'($urandom_range(1));
        c.mem = ($urandom_range(2) == 0);
        return c;
    endfunction

    function automatic int lat_of(logic mem);
        return mem ? MEM_L : ALU_L;
    endfunction

    function automatic bit busy(logic [4:0] r);
        return ready_at[r] > cyc;
    endfunction

    function automatic bit port_taken(int k, int due);
        if (k == 1) begin
            foreach (pq1[i]) if (pq1[i].due == due) return 1'b1;
        end else begin
            foreach (pq2[i]) if (pq2[i].due == due) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic chk(string name, int act, int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic chk_wr(string name, int wr_act, int a_act, int w);
        if (w == 32) chk(name, wr_act, 1);
        else if (w >= 0) begin
            chk(name, wr_act, 0);
            chk({name, "_addr"}, a_act, w);
        end
    endtask

    // Drive one cycle, predict every output, queue the prediction; x*/w* add
    // optional hand-derived checks (-1 = none, w = 32 means "no write").
    task automatic drive(cand_t c1, cand_t c2, logic rst, int x1, int x2, int w1, int w2,
                         output logic i1, output logic i2);
        exp_t e;
        int   l1, l2;
        reset = rst;
        V1 = c1.v; SA1 = c1.sa; UA1 = c1.ua; SB1 = c1.sb; UB1 = c1.ub;
        DST1 = c1.dst; WR1 = c1.wr; MEM1 = c1.mem;
        V2 = c2.v; SA2 = c2.sa; UA2 = c2.ua; SB2 = c2.sb; UB2 = c2.ub;
        DST2 = c2.dst; WR2 = c2.wr; MEM2 = c2.mem;
        l1 = lat_of(c1.mem);
        l2 = lat_of(c2.mem);
        e.i1 = !rst && c1.v && !(c1.ua && busy(c1.sa)) && !(c1.ub && busy(c1.sb))
               && (!c1.wr || (!port_taken(1, cyc + l1) && !busy(c1.dst)));
        e.i2 = e.i1 && c2.v && !(c2.ua && busy(c2.sa)) && !(c2.ub && busy(c2.sb))
               && (!c2.wr || (!port_taken(2, cyc + l2) && !busy(c2.dst)))
               && !(c1.wr && c2.ua && c2.sa == c1.dst) && !(c1.wr && c2.ub && c2.sb == c1.dst)
               && !(c1.wr && c2.wr && c1.dst == c2.dst) && !(c1.mem && c2.mem);
        e.st  = !rst && c1.v && !e.i1;
        e.rd1 = !e.i1;
        e.rd2 = !e.i2;
        e.wr1 = 1'b1; e.a1 = 5'd0; e.wr2 = 1'b1; e.a2 = 5'd0; e.c = cyc;
        foreach (pq1[i]) if (pq1[i].due == cyc) begin e.wr1 = 1'b0; e.a1 = pq1[i].addr; end
        foreach (pq2[i]) if (pq2[i].due == cyc) begin e.wr2 = 1'b0; e.a2 = pq2[i].addr; end
        expq.push_back(e);
        if (rst) begin
            pq1.delete();
            pq2.delete();
            foreach (ready_at[r]) ready_at[r] = 0;
        end else begin
            if (e.i1 && c1.wr) begin
                pq1.push_back('{cyc + l1, c1.dst});
                if (c1.dst != 0) ready_at[c1.dst] = cyc + l1 + 1;
            end
            if (e.i2 && c2.wr) begin
                pq2.push_back('{cyc + l2, c2.dst});
                if (c2.dst != 0) ready_at[c2.dst] = cyc + l2 + 1;
            end
            for (int i = pq1.size() - 1; i >= 0; i--) if (pq1[i].due <= cyc) pq1.delete(i);
            for (int i = pq2.size() - 1; i >= 0; i--) if (pq2[i].due <= cyc) pq2.delete(i);
        end
        i1 = e.i1;
        i2 = e.i2;
        @(negedge clk);
        if (x1 >= 0) chk("dir_issue1", int'(ISSUE1), x1);
        if (x2 >= 0) chk("dir_issue2", int'(ISSUE2), x2);
        chk_wr("dir_regwr1", int'(REG_WR1), int'(DIR_WRA1), w1);
        chk_wr("dir_regwr2", int'(REG_WR2), int'(DIR_WRA2), w2);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                mon_e = expq.pop_front();
                chk("issue1", int'(ISSUE1), int'(mon_e.i1));
                chk("issue2", int'(ISSUE2), int'(mon_e.i2));
                chk("stall", int'(STALL), int'(mon_e.st));
                chk("reg_rd1", int'(REG_RD1), int'(mon_e.rd1));
                chk("reg_rd2", int'(REG_RD2), int'(mon_e.rd2));
                chk("reg_wr1", int'(REG_WR1), int'(mon_e.wr1));
                chk("reg_wr2", int'(REG_WR2), int'(mon_e.wr2));
                chk("dir_wra1", int'(DIR_WRA1), int'(mon_e.a1));
                chk("dir_wra2", int'(DIR_WRA2), int'(mon_e.a2));
                $display("cyc %0d: issue=%b%b stall=%b wr=%b%b wra=%0d/%0d", mon_e.c,
                         ISSUE1, ISSUE2, STALL, REG_WR1, REG_WR2, DIR_WRA1, DIR_WRA2);
            end
        end
    end

    initial begin
        cand_t nop, a, b;
        logic  i1, i2;
        n_pass = 0; n_total = 0; cyc = 0;
        foreach (ready_at[r]) ready_at[r] = 0;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        V1 = 0; V2 = 0; SA1 = 0; SB1 = 0; SA2 = 0; SB2 = 0; UA1 = 0; UB1 = 0; UA2 = 0; UB2 = 0;
        DST1 = 0; DST2 = 0; WR1 = 0; WR2 = 0; MEM1 = 0; MEM2 = 0;
        @(posedge clk);
        #1;
        cyc = 1;
        drive(mk(1, 0, 0, 0, 0, 1, 1, 0), nop, 1, 0, 0, 32, 32, i1, i2);
        chk("reset_stall", int'(STALL), 0);
        drive(nop, nop, 1, 0, 0, 32, 32, i1, i2);

        // Independent pair.
        drive(mk(1, 1, 1, 2, 1, 3, 1, 0), mk(1, 1, 1, 2, 0, 4, 1, 0), 0, 1, 1, -1, -1, i1, i2);
        drive(nop, nop, 0, -1, -1, 3, 4, i1, i2);
        drive(nop, nop, 0, -1, -1, 32, 32, i1, i2);
        // Load-use.
        drive(mk(1, 1, 1, 0, 0, 5, 1, 1), nop, 0, 1, -1, -1, -1, i1, i2);
        drive(mk(1, 5, 1, 0, 0, 6, 1, 0), nop, 0, 0, -1, -1, -1, i1, i2);
        drive(mk(1, 5, 1, 0, 0, 6, 1, 0), nop, 0, 0, -1, 5, -1, i1, i2);
        drive(mk(1, 5, 1, 0, 0, 6, 1, 0), nop, 0, 1, -1, 32, -1, i1, i2);
        drive(nop, nop, 0, -1, -1, -1, -1, i1, i2);
        // Intra-pair RAW, slot 2 re-presented.
        a = mk(1, 2, 1, 0, 0, 8, 0, 0);
        drive(mk(1, 1, 1, 0, 0, 7, 1, 0), mk(1, 7, 1, 0, 0, 8, 0, 0), 0, 1, 0, -1, -1, i1, i2);
        drive(mk(1, 1, 1, 0, 0, 10, 1, 0), mk(1, 7, 1, 0, 0, 8, 0, 0), 0, 1, 0, 7, -1, i1, i2);
        drive(mk(1, 1, 1, 0, 0, 11, 1, 0), mk(1, 7, 1, 0, 0, 8, 0, 0), 0, 1, 1, 10, -1, i1, i2);
        drive(nop, a, 0, -1, 0, -1, -1, i1, i2);
        drive(nop, nop, 0, -1, -1, -1, -1, i1, i2);
        // Port collision on slot 1.
        drive(mk(1, 0, 0, 0, 0, 12, 1, 1), nop, 0, 1, -1, -1, -1, i1, i2);
        drive(mk(1, 0, 0, 0, 0, 13, 1, 0), nop, 0, 0, -1, -1, -1, i1, i2);
        drive(mk(1, 0, 0, 0, 0, 13, 1, 0), nop, 0, 1, -1, 12, -1, i1, i2);
        drive(nop, nop, 0, -1, -1, 13, -1, i1, i2);
        // Two memory ops, then WAW on r9.
        drive(mk(1, 0, 0, 0, 0, 14, 1, 1), mk(1, 1, 1, 0, 0, 0, 0, 1), 0, 1, 0, -1, -1, i1, i2);
        drive(nop, nop, 0, -1, -1, -1, -1, i1, i2);
        drive(mk(1, 0, 0, 0, 0, 9, 1, 0), mk(1, 0, 0, 0, 0, 9, 1, 0), 0, 1, 0, -1, -1, i1, i2);
        drive(nop, nop, 0, -1, -1, 9, 32, i1, i2);
        // Writes to r0 never set busy.
        drive(mk(1, 0, 0, 0, 0, 0, 1, 0), nop, 0, 1, -1, -1, -1, i1, i2);
        drive(mk(1, 0, 1, 0, 1, 15, 1, 0), nop, 0, 1, -1, 0, -1, i1, i2);
        drive(nop, nop, 0, -1, -1, -1, -1, i1, i2);
        // Reset one cycle after a load drops the write and clears the scoreboard.
        drive(mk(1, 0, 0, 0, 0, 5, 1, 1), nop, 0, 1, -1, -1, -1, i1, i2);
        drive(mk(1, 0, 0, 0, 0, 16, 1, 0), nop, 1, 0, 0, -1, -1, i1, i2);
        chk("reset_stall_mid", int'(STALL), 0);
        drive(mk(1, 5, 1, 0, 0, 17, 0, 0), nop, 0, 1, -1, 32, 32, i1, i2);
        drive(nop, nop, 0, -1, -1, -1, -1, i1, i2);

        // Randomized traffic; the front end holds stalled or unissued slots.
        a = rnd();
        b = rnd();
        for (int n = 0; n < 500; n++) begin
            logic rst;
            rst = ($urandom_range(59) == 0);
            drive(a, b, rst, -1, -1, -1, -1, i1, i2);
            if (i1 || !a.v) begin
                a = rnd();
                if (i2 || !b.v) b = rnd();
            end
        end
        for (int n = 0; n < 4; n++) drive(nop, nop, 0, -1, -1, -1, -1, i1, i2);
        @(negedge clk);
        chk("queue_drained", expq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
